// File: rtl/aftab_trap_pkg.sv
// Shared definitions for the AFTAB trap sequencer: FSM state encoding,
// CSR addresses for the machine and user banks, status bit positions and
// the vectored tvec mode encoding.
package aftab_trap_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DELEG,
        WR_EPC,
        WR_CAUSE,
        WR_TVAL,
        RD_STATUS,
        WR_STATUS,
        RD_TVEC,
        LOAD_PC,
        RET_RD_EPC,
        RET_RD_STATUS,
        RET_WR_STATUS,
        RET_LOAD_PC
    } trapStateT;

    // Machine bank CSR addresses
    localparam logic [11:0] M_EPC    = 12'h341;
    localparam logic [11:0] M_CAUSE  = 12'h342;
    localparam logic [11:0] M_TVAL   = 12'h343;
    localparam logic [11:0] M_STATUS = 12'h300;
    localparam logic [11:0] M_TVEC   = 12'h305;

    // User bank CSR addresses
    localparam logic [11:0] U_EPC    = 12'h041;
    localparam logic [11:0] U_CAUSE  = 12'h042;
    localparam logic [11:0] U_TVAL   = 12'h043;
    localparam logic [11:0] U_STATUS = 12'h000;
    localparam logic [11:0] U_TVEC   = 12'h005;

    // Status register bit positions
    localparam int MIE    = 3;
    localparam int MPIE   = 7;
    localparam int MPP_LO = 11;
    localparam int MPP_HI = 12;
    localparam int UIE    = 0;
    localparam int UPIE   = 4;

    localparam logic [1:0] TVEC_VECTORED = 2'b01;
    localparam logic [1:0] PRV_MACHINE   = 2'b11;

    function automatic logic [11:0] bankAddr(input logic bankM,
                                             input logic [11:0] mAddr,
                                             input logic [11:0] uAddr);
        return bankM ? mAddr : uAddr;
    endfunction

endpackage

// File: rtl/aftab_trap_vector_calc.sv
// Trap target computation from the tvec CSR and the latched cause.
//   tvec   : tvec CSR value (mode in bits 1:0)
//   cause  : trap cause, bit len-1 set for interrupts
//   pcNext : base address, or base + 4*cause for vectored interrupts
module aftab_trap_vector_calc
    import aftab_trap_pkg::*;
#(
    parameter int len = 32
) (
    input  logic [len-1:0] tvec,
    input  logic [len-1:0] cause,
    output logic [len-1:0] pcNext
);

    logic [len-1:0] base;
    logic [len-1:0] offset;

    always_comb begin
        base   = {tvec[len-1:2], 2'b00};
        // Shifting left by two drops the interrupt flag, leaving the
        // exception code scaled to a word offset; the sum wraps naturally.
        offset = cause << 2;
        if (tvec[1:0] == TVEC_VECTORED && cause[len-1]) begin
            pcNext = base + offset;
        end else begin
            pcNext = base;
        end
    end

endmodule

// File: rtl/aftab_trap_sequencer.sv
// Trap entry / trap return sequencer for the AFTAB interrupt datapath.
// Accepts a trap, mret or uret at an instruction boundary, walks the CSR
// file through a fixed read/write order, then loads the new PC and switches
// privilege.
//   Inputs : instrBoundary, exceptionRaise, interruptRaise, mretDetect,
//            uretDetect, causeCode, trapValue, curPC, curPRV,
//            delegationMode (valid the cycle after ldDelegation),
//            csrRdData (valid the cycle after csrRdEn)
//   Outputs: ldDelegation, ldMachine, ldUser, csrAddr, csrWrEn, csrRdEn,
//            csrWrData, pcLoad, pcNext, busy, trapDone
module aftab_trap_sequencer
    import aftab_trap_pkg::*;
#(
    parameter int len = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instrBoundary,
    input  logic           exceptionRaise,
    input  logic           interruptRaise,
    input  logic           mretDetect,
    input  logic           uretDetect,
    input  logic [len-1:0] causeCode,
    input  logic [len-1:0] trapValue,
    input  logic [len-1:0] curPC,
    input  logic [1:0]     curPRV,
    input  logic [1:0]     delegationMode,
    input  logic [len-1:0] csrRdData,
    output logic           ldDelegation,
    output logic           ldMachine,
    output logic           ldUser,
    output logic [11:0]    csrAddr,
    output logic           csrWrEn,
    output logic           csrRdEn,
    output logic [len-1:0] csrWrData,
    output logic           pcLoad,
    output logic [len-1:0] pcNext,
    output logic           busy,
    output logic           trapDone
);

    trapStateT      state;
    logic           bankM;
    logic           retMachine;
    logic [len-1:0] causeL;
    logic [len-1:0] tvalL;
    logic [len-1:0] pcL;
    logic [len-1:0] epcL;
    logic [1:0]     prvL;
    logic [len-1:0] vecPC;

    function automatic logic [len-1:0] entryStatus(input logic [len-1:0] s,
                                                   input logic bm,
                                                   input logic [1:0] prv);
        logic [len-1:0] r;
        r = s;
        if (bm) begin
            r[MPIE]          = s[MIE];
            r[MIE]           = 1'b0;
            r[MPP_HI:MPP_LO] = prv;
        end else begin
            r[UPIE] = s[UIE];
            r[UIE]  = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [len-1:0] retStatus(input logic [len-1:0] s,
                                                 input logic bm);
        logic [len-1:0] r;
        r = s;
        if (bm) begin
            r[MIE]           = s[MPIE];
            r[MPIE]          = 1'b1;
            r[MPP_HI:MPP_LO] = 2'b00;
        end else begin
            r[UIE]  = s[UPIE];
            r[UPIE] = 1'b1;
        end
        return r;
    endfunction

    // tvec arrives on csrRdData during LOAD_PC
    aftab_trap_vector_calc #(.len(len)) uVec (
        .tvec   (csrRdData),
        .cause  (causeL),
        .pcNext (vecPC)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bankM      <= 1'b0;
            retMachine <= 1'b0;
            causeL     <= '0;
            tvalL      <= '0;
            pcL        <= '0;
            epcL       <= '0;
            prvL       <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (instrBoundary) begin
                        // Exception and interrupt share one path: the
                        // checker has already chosen the cause to report.
                        if (exceptionRaise || interruptRaise) begin
                            causeL <= causeCode;
                            tvalL  <= trapValue;
                            pcL    <= curPC;
                            prvL   <= curPRV;
                            state  <= DELEG;
                        end else if (mretDetect) begin
                            bankM <= 1'b1;
                            state <= RET_RD_EPC;
                        end else if (uretDetect) begin
                            bankM <= 1'b0;
                            state <= RET_RD_EPC;
                        end
                    end
                end
                DELEG: begin
                    bankM <= (delegationMode == PRV_MACHINE);
                    state <= WR_EPC;
                end
                WR_EPC:    state <= WR_CAUSE;
                WR_CAUSE:  state <= WR_TVAL;
                WR_TVAL:   state <= RD_STATUS;
                RD_STATUS: state <= WR_STATUS;
                WR_STATUS: state <= RD_TVEC;
                RD_TVEC:   state <= LOAD_PC;
                LOAD_PC:   state <= IDLE;
                RET_RD_EPC: state <= RET_RD_STATUS;
                RET_RD_STATUS: begin
                    epcL  <= csrRdData;
                    state <= RET_WR_STATUS;
                end
                RET_WR_STATUS: begin
                    // Only mret can return to machine mode, via the old MPP
                    retMachine <= bankM && (csrRdData[MPP_HI:MPP_LO] == PRV_MACHINE);
                    state      <= RET_LOAD_PC;
                end
                RET_LOAD_PC: state <= IDLE;
                default:     state <= IDLE;
            endcase
        end
    end

    // Outputs decode from the state register; status and tvec read data
    // are consumed combinationally in the cycle they become valid.
    always_comb begin
        ldDelegation = 1'b0;
        ldMachine    = 1'b0;
        ldUser       = 1'b0;
        csrAddr      = 12'h000;
        csrWrEn      = 1'b0;
        csrRdEn      = 1'b0;
        csrWrData    = '0;
        pcLoad       = 1'b0;
        pcNext       = '0;
        busy         = (state != IDLE);
        trapDone     = 1'b0;
        case (state)
            IDLE: ldDelegation = !rst && instrBoundary && (exceptionRaise || interruptRaise);
            WR_EPC: begin
                csrWrEn   = 1'b1;
                csrAddr   = bankAddr(bankM, M_EPC, U_EPC);
                csrWrData = pcL;
            end
            WR_CAUSE: begin
                csrWrEn   = 1'b1;
                csrAddr   = bankAddr(bankM, M_CAUSE, U_CAUSE);
                csrWrData = causeL;
            end
            WR_TVAL: begin
                csrWrEn   = 1'b1;
                csrAddr   = bankAddr(bankM, M_TVAL, U_TVAL);
                csrWrData = tvalL;
            end
            RD_STATUS: begin
                csrRdEn = 1'b1;
                csrAddr = bankAddr(bankM, M_STATUS, U_STATUS);
            end
            WR_STATUS: begin
                csrWrEn   = 1'b1;
                csrAddr   = bankAddr(bankM, M_STATUS, U_STATUS);
                csrWrData = entryStatus(csrRdData, bankM, prvL);
            end
            RD_TVEC: begin
                csrRdEn = 1'b1;
                csrAddr = bankAddr(bankM, M_TVEC, U_TVEC);
            end
            LOAD_PC: begin
                pcLoad    = 1'b1;
                trapDone  = 1'b1;
                pcNext    = vecPC;
                ldMachine = bankM;
                ldUser    = !bankM;
            end
            RET_RD_EPC: begin
                csrRdEn = 1'b1;
                csrAddr = bankAddr(bankM, M_EPC, U_EPC);
            end
            RET_RD_STATUS: begin
                csrRdEn = 1'b1;
                csrAddr = bankAddr(bankM, M_STATUS, U_STATUS);
            end
            RET_WR_STATUS: begin
                csrWrEn   = 1'b1;
                csrAddr   = bankAddr(bankM, M_STATUS, U_STATUS);
                csrWrData = retStatus(csrRdData, bankM);
            end
            RET_LOAD_PC: begin
                pcLoad    = 1'b1;
                trapDone  = 1'b1;
                pcNext    = epcL;
                ldMachine = retMachine;
                ldUser    = !retMachine;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aftab_trap_sequencer.sv
module tb_aftab_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instrBoundary = 1'b0;
    logic        exceptionRaise = 1'b0;
    logic        interruptRaise = 1'b0;
    logic        mretDetect = 1'b0;
    logic        uretDetect = 1'b0;
    logic [31:0] causeCode = '0;
    logic [31:0] trapValue = '0;
    logic [31:0] curPC = '0;
    logic [1:0]  curPRV = 2'b00;
    logic [1:0]  delegationMode = 2'b00;
    logic [31:0] csrRdData = '0;
    logic        ldDelegation, ldMachine, ldUser, csrWrEn, csrRdEn;
    logic        pcLoad, busy, trapDone;
    logic [11:0] csrAddr;
    logic [31:0] csrWrData, pcNext;

    int total = 0;
    int bad = 0;

    logic [31:0] csrMem [0:4095];
    logic [1:0]  delegTarget = 2'b11;
    logic [43:0] wrLog [$];
    logic [11:0] rdLog [$];

    aftab_trap_sequencer #(.len(32)) dut (
        .clk(clk), .rst(rst), .instrBoundary(instrBoundary),
        .exceptionRaise(exceptionRaise), .interruptRaise(interruptRaise),
        .mretDetect(mretDetect), .uretDetect(uretDetect),
        .causeCode(causeCode), .trapValue(trapValue), .curPC(curPC),
        .curPRV(curPRV), .delegationMode(delegationMode),
        .csrRdData(csrRdData), .ldDelegation(ldDelegation),
        .ldMachine(ldMachine), .ldUser(ldUser), .csrAddr(csrAddr),
        .csrWrEn(csrWrEn), .csrRdEn(csrRdEn), .csrWrData(csrWrData),
        .pcLoad(pcLoad), .pcNext(pcNext), .busy(busy), .trapDone(trapDone)
    );

    always #5 clk = ~clk;

    // CSR file: synchronous read, garbage on the bus when no read was issued
    always @(posedge clk) begin
        if (csrRdEn) csrRdData <= csrMem[csrAddr];
        else         csrRdData <= $urandom;
    end

    // Delegation register fed by the checker
    always @(posedge clk) begin
        if (ldDelegation) delegationMode <= delegTarget;
    end

    typedef struct {
        logic        exc, intr, mret, uret;
        logic [31:0] cause, tval, pc;
        logic [1:0]  prv, deleg;
        logic [31:0] statusInit, tvecInit, epcInit;
        logic [31:0] expStatus, expPc;
        logic        expMachine, expBankM;
    } vecT;

    vecT tbl [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vecT mk(input logic e, input logic i, input logic m, input logic u,
                               input logic [31:0] cause, input logic [31:0] tval,
                               input logic [31:0] pc, input logic [1:0] prv,
                               input logic [1:0] deleg, input logic [31:0] st,
                               input logic [31:0] tv, input logic [31:0] epc,
                               input logic [31:0] eSt, input logic [31:0] ePc,
                               input logic eM, input logic eB);
        vecT v;
        v.exc = e; v.intr = i; v.mret = m; v.uret = u;
        v.cause = cause; v.tval = tval; v.pc = pc; v.prv = prv; v.deleg = deleg;
        v.statusInit = st; v.tvecInit = tv; v.epcInit = epc;
        v.expStatus = eSt; v.expPc = ePc; v.expMachine = eM; v.expBankM = eB;
        return v;
    endfunction

    // Reference model: privileged-spec rules in plain arithmetic
    function automatic vecT refModel(input vecT v);
        vecT r;
        logic [31:0] s, base;
        r = v;
        s = v.statusInit;
        if (v.exc || v.intr) begin
            r.expBankM = (v.deleg == 2'b11);
            if (r.expBankM)
                r.expStatus = (s & ~32'h1888) | (((s >> 3) & 32'd1) << 7) | (32'(v.prv) << 11);
            else
                r.expStatus = (s & ~32'h11) | ((s & 32'd1) << 4);
            base = v.tvecInit & ~32'h3;
            if ((v.tvecInit & 32'h3) == 32'h1 && v.cause[31])
                r.expPc = base + (v.cause & 32'h7fffffff) * 32'd4;
            else
                r.expPc = base;
            r.expMachine = r.expBankM;
        end else begin
            r.expBankM = v.mret;
            if (v.mret) begin
                r.expStatus  = (s & ~32'h1888) | (((s >> 7) & 32'd1) << 3) | 32'h80;
                r.expMachine = ((s >> 11) & 32'd3) == 32'd3;
            end else begin
                r.expStatus  = (s & ~32'h11) | ((s >> 4) & 32'd1) | 32'h10;
                r.expMachine = 1'b0;
            end
            r.expPc = v.epcInit;
        end
        return r;
    endfunction

    function automatic logic [11:0] addrOf(input logic bm, input logic [11:0] mAddr);
        return bm ? mAddr : (mAddr & 12'h0ff);
    endfunction

    task automatic dropInputs();
        instrBoundary = 0; exceptionRaise = 0; interruptRaise = 0;
        mretDetect = 0; uretDetect = 0;
    endtask

    task automatic runCase(input vecT v, input bit hold, input string nm);
        logic isRet, bm;
        int ldCnt, busyCnt, loadCyc, protoBad;
        logic [31:0] pcAt;
        logic mAt, uAt, doneAt;
        logic [43:0] expWr [$];
        logic [11:0] expRd [$];
        isRet = !(v.exc || v.intr);
        bm = v.expBankM;
        csrMem[12'h300] = v.statusInit; csrMem[12'h000] = v.statusInit;
        csrMem[12'h305] = v.tvecInit;   csrMem[12'h005] = v.tvecInit;
        csrMem[12'h341] = v.epcInit;    csrMem[12'h041] = v.epcInit;
        delegTarget = v.deleg;
        wrLog.delete(); rdLog.delete();
        busyCnt = 0; loadCyc = 0; protoBad = 0;
        pcAt = '0; mAt = 0; uAt = 0; doneAt = 0;
        @(negedge clk);
        instrBoundary = 1; exceptionRaise = v.exc; interruptRaise = v.intr;
        mretDetect = v.mret; uretDetect = v.uret;
        causeCode = v.cause; trapValue = v.tval; curPC = v.pc; curPRV = v.prv;
        #1 ldCnt = int'(ldDelegation);
        for (int cyc = 1; cyc <= 20 && loadCyc == 0; cyc++) begin
            @(negedge clk);
            if (!hold) begin
                dropInputs();
                causeCode = $urandom; trapValue = $urandom; curPC = $urandom;
                curPRV = 2'($urandom);
            end
            #1;
            busyCnt += int'(busy);
            ldCnt += int'(ldDelegation);
            if (csrWrEn) wrLog.push_back({csrAddr, csrWrData});
            else if (csrWrData != 0) protoBad++;
            if (csrRdEn) rdLog.push_back(csrAddr);
            if (csrRdEn && csrWrEn) protoBad++;
            if (pcLoad) begin
                loadCyc = cyc; pcAt = pcNext; mAt = ldMachine; uAt = ldUser; doneAt = trapDone;
                dropInputs();
            end
        end
        if (isRet) begin
            expRd.push_back(addrOf(bm, 12'h341));
            expRd.push_back(addrOf(bm, 12'h300));
            expWr.push_back({addrOf(bm, 12'h300), v.expStatus});
        end else begin
            expRd.push_back(addrOf(bm, 12'h300));
            expRd.push_back(addrOf(bm, 12'h305));
            expWr.push_back({addrOf(bm, 12'h341), v.pc});
            expWr.push_back({addrOf(bm, 12'h342), v.cause});
            expWr.push_back({addrOf(bm, 12'h343), v.tval});
            expWr.push_back({addrOf(bm, 12'h300), v.expStatus});
        end
        chk({nm, "_latency"}, 64'(loadCyc), isRet ? 64'd4 : 64'd8);
        chk({nm, "_busy"}, 64'(busyCnt), isRet ? 64'd4 : 64'd8);
        chk({nm, "_ldDeleg"}, 64'(ldCnt), isRet ? 64'd0 : 64'd1);
        chk({nm, "_proto"}, 64'(protoBad), 64'd0);
        chk({nm, "_pcNext"}, 64'(pcAt), 64'(v.expPc));
        chk({nm, "_priv"}, {61'd0, mAt, uAt, doneAt}, {61'd0, v.expMachine, !v.expMachine, 1'b1});
        chk({nm, "_nWr"}, 64'(wrLog.size()), 64'(expWr.size()));
        for (int k = 0; k < expWr.size() && k < wrLog.size(); k++)
            chk($sformatf("%s_wr%0d", nm, k), 64'(wrLog[k]), 64'(expWr[k]));
        chk({nm, "_nRd"}, 64'(rdLog.size()), 64'(expRd.size()));
        for (int k = 0; k < expRd.size() && k < rdLog.size(); k++)
            chk($sformatf("%s_rd%0d", nm, k), 64'(rdLog[k]), 64'(expRd[k]));
        @(negedge clk);
        #1 chk({nm, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        vecT rv;
        int wrCnt;
        for (int a = 0; a < 4096; a++) csrMem[a] = '0;
        //            e i m u  cause         tval          pc            prv    deleg  status        tvec          epc           expStatus     expPc         M  bankM
        tbl[0] = mk(1,0,0,0, 32'h2,        32'h13,       32'h100,      2'b00, 2'b11, 32'h8,        32'h80000000, 32'h0,        32'h80,       32'h80000000, 1, 1);
        tbl[1] = mk(0,1,0,0, 32'h80000007, 32'h0,        32'h200,      2'b11, 2'b11, 32'h8,        32'h80000001, 32'h0,        32'h1880,     32'h8000001C, 1, 1);
        tbl[2] = mk(0,1,0,0, 32'h80000000, 32'h0,        32'h240,      2'b00, 2'b00, 32'h1,        32'h2000,     32'h0,        32'h10,       32'h2000,     0, 0);
        tbl[3] = mk(1,1,1,0, 32'h5,        32'h44,       32'h300,      2'b11, 2'b11, 32'h0,        32'h1000,     32'hdead,     32'h1800,     32'h1000,     1, 1);
        tbl[4] = mk(0,0,1,0, 32'h0,        32'h0,        32'h0,        2'b11, 2'b11, 32'h80,       32'h0,        32'h400,      32'h88,       32'h400,      0, 1);
        tbl[5] = mk(0,0,0,1, 32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 32'h10,       32'h0,        32'h500,      32'h11,       32'h500,      0, 0);
        tbl[6] = mk(0,0,1,0, 32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 32'h1880,     32'h0,        32'h800,      32'h88,       32'h800,      1, 1);
        tbl[7] = mk(1,0,0,0, 32'h3,        32'h0,        32'h600,      2'b00, 2'b11, 32'h0,        32'h4001,     32'h0,        32'h0,        32'h4000,     1, 1);
        tbl[8] = mk(0,1,0,0, 32'h80000003, 32'h0,        32'h0,        2'b11, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0,        32'hFFFFFFF7, 32'h8,        1, 1);
        tbl[9] = mk(1,0,0,0, 32'h8,        32'h0,        32'h700,      2'b00, 2'b01, 32'h11,       32'h3000,     32'h0,        32'h10,       32'h3000,     0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctrl", {52'd0, ldDelegation, ldMachine, ldUser, csrWrEn, csrRdEn, pcLoad, busy, trapDone, csrAddr},
            64'd0);
        chk("reset_data", {csrWrData, pcNext}, 64'd0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 10; i++) runCase(tbl[i], 1'b0, $sformatf("tbl%0d", i));

        // Reset in the middle of trap entry
        csrMem[12'h300] = 32'h8; csrMem[12'h305] = 32'h100;
        delegTarget = 2'b11;
        @(negedge clk);
        instrBoundary = 1; exceptionRaise = 1; causeCode = 32'h7; trapValue = 32'h55;
        curPC = 32'h900; curPRV = 2'b11;
        @(negedge clk);
        dropInputs();
        repeat (2) @(negedge clk);
        #1 chk("midrst_in_cause", {51'd0, csrWrEn, csrAddr}, {51'd0, 1'b1, 12'h342});
        rst = 1;
        #1;
        chk("midrst_ctrl", {52'd0, ldDelegation, ldMachine, ldUser, csrWrEn, csrRdEn, pcLoad, busy, trapDone, csrAddr},
            64'd0);
        chk("midrst_data", {csrWrData, pcNext}, 64'd0);
        @(negedge clk);
        rst = 0;
        wrCnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1 wrCnt += int'(csrWrEn) + int'(busy);
        end
        chk("midrst_no_activity", 64'(wrCnt), 64'd0);
        runCase(tbl[1], 1'b0, "after_rst");

        // Randomized traps and returns, raises sometimes held through the sequence
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            rv = mk(0,0,0,0, 0,0,0, 2'b00, 2'b00, 0,0,0, 0,0,0,0);
            rv.exc  = (kind == 0);
            rv.intr = (kind == 1) || (kind == 0 && $urandom_range(0, 1) == 1);
            rv.mret = (kind == 2) || (kind < 2 && $urandom_range(0, 1) == 1);
            rv.uret = (kind == 3) || $urandom_range(0, 1) == 1;
            rv.cause = (kind == 1) ? {1'b1, 31'($urandom)} : {1'b0, 31'($urandom_range(0, 15))};
            rv.tval = $urandom; rv.pc = $urandom;
            rv.prv = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            rv.deleg = 2'($urandom);
            rv.statusInit = $urandom;
            rv.tvecInit = ($urandom_range(0, 1) == 1) ? ({$urandom} & ~32'h3) | 32'h1 : $urandom;
            rv.epcInit = $urandom;
            rv = refModel(rv);
            runCase(rv, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
